// File: rtl/jtag_arb.sv
// Round-robin arbiter sharing one JTAG engine and its IR/DR FIFO pair; watchdog built only with JTAG_ARB_TIMEOUT_EN.
// gnt/wr one cycle after the request is sampled, work one cycle later; holds in PUSH while either FIFO is full.
module jtag_arb #(
   parameter int NUM_REQ          = 2,
   parameter int DATA_INSTRUCTION = 10,
   parameter int DATA_FIFO        = 8,
   parameter int TIMEOUT          = 255
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_REQ-1:0]                  req,
   input  logic [NUM_REQ*DATA_INSTRUCTION-1:0] req_ir,
   input  logic [NUM_REQ*DATA_FIFO-1:0]        req_dr,
   input  logic [NUM_REQ-1:0]                  req_op,
   output logic [NUM_REQ-1:0]                  gnt,
   output logic [NUM_REQ-1:0]                  done,
   output logic                                err,
   output logic [DATA_INSTRUCTION-1:0]         wdata_instruction,
   output logic                                wr_instruction,
   input  logic                                full_instruction,
   output logic [DATA_FIFO-1:0]                wdata_data,
   output logic                                wr_data,
   input  logic                                full_data,
   output logic                                work,
   output logic                                op,
   input  logic                                busy
);

   localparam int IW = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
      $error("jtag_arb: parameter out of range");
   end

   typedef enum logic [2:0] {IDLE, PUSH, START, WAIT_BUSY, WAIT_DONE} state_t;

   typedef struct packed {
      logic [IW-1:0]               owner;
      logic [DATA_INSTRUCTION-1:0] ir;
      logic [DATA_FIFO-1:0]        dr;
      logic                        op;
   } txn_t;

   state_t               state_q, state_d;
   txn_t                 txn_q, txn_d;
   logic [IW-1:0]        last_q, last_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic                 wr_q, wr_d;
   logic                 work_q, work_d;
   logic                 op_q, op_d;

   logic                 win_vld;
   logic [IW-1:0]        win_idx;
   logic [IW-1:0]        cand;
   txn_t                 win_txn;

   // Rotating search: the requester after the last owner has highest priority.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IW'((int'(last_q) + k) % NUM_REQ);
         if (!win_vld && req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   always_comb begin
      win_txn       = '0;
      win_txn.owner = win_idx;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == IW'(i)) begin
            win_txn.ir = req_ir[i*DATA_INSTRUCTION +: DATA_INSTRUCTION];
            win_txn.dr = req_dr[i*DATA_FIFO +: DATA_FIFO];
            win_txn.op = req_op[i];
         end
      end
   end

`ifdef JTAG_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          tmo;

   assign tmo = (cnt_q == CW'(TIMEOUT - 1));
`endif

   always_comb begin
      state_d = state_q;
      txn_d   = txn_q;
      last_d  = last_q;
      gnt_d   = '0;
      done_d  = '0;
      wr_d    = 1'b0;
      work_d  = 1'b0;
      op_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               txn_d   = win_txn;
               state_d = PUSH;
            end
         end
         PUSH: begin
            // Both words go in the same cycle or neither does.
            if (!full_instruction && !full_data) begin
               wr_d    = 1'b1;
               gnt_d   = NUM_REQ'(1) << txn_q.owner;
               last_d  = txn_q.owner;
               state_d = START;
            end
         end
         START: begin
            work_d  = 1'b1;
            op_d    = txn_q.op;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (busy) begin
               state_d = WAIT_DONE;
            end
`ifdef JTAG_ARB_TIMEOUT_EN
            else if (tmo) begin
               state_d = IDLE;
            end
`endif
         end
         WAIT_DONE: begin
            if (!busy) begin
               done_d  = NUM_REQ'(1) << txn_q.owner;
               state_d = IDLE;
            end
`ifdef JTAG_ARB_TIMEOUT_EN
            else if (tmo) begin
               state_d = IDLE;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef JTAG_ARB_TIMEOUT_EN
   // Counter restarts whenever a wait state is entered; it never wraps because tmo leaves the state.
   always_comb begin
      cnt_d = '0;
      err_d = 1'b0;
      if ((state_q == WAIT_BUSY || state_q == WAIT_DONE) && state_d == state_q) begin
         cnt_d = cnt_q + CW'(1);
      end
      if ((state_q == WAIT_BUSY && !busy && tmo) || (state_q == WAIT_DONE && busy && tmo)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         txn_q   <= '0;
         last_q  <= IW'(NUM_REQ - 1);
         gnt_q   <= '0;
         done_q  <= '0;
         wr_q    <= 1'b0;
         work_q  <= 1'b0;
         op_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         txn_q   <= txn_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         wr_q    <= wr_d;
         work_q  <= work_d;
         op_q    <= op_d;
      end
   end

   assign gnt               = gnt_q;
   assign done              = done_q;
   assign wr_instruction    = wr_q;
   assign wr_data           = wr_q;
   assign wdata_instruction = wr_q ? txn_q.ir : '0;
   assign wdata_data        = wr_q ? txn_q.dr : '0;
   assign work              = work_q;
   assign op                = op_q;

endmodule

// File: tb/tb_jtag_arb.sv
// Bench for jtag_arb: directed and random transactions checked against a round-robin reference model.
module tb_jtag_arb;

   localparam int N   = 3;
   localparam int DI  = 10;
   localparam int DF  = 8;
   localparam int TO  = 20;
   localparam int IRW = N * DI;
   localparam int DRW = N * DF;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N-1:0]    req = '0;
   logic [IRW-1:0]  req_ir = '0;
   logic [DRW-1:0]  req_dr = '0;
   logic [N-1:0]    req_op = '0;
   logic [N-1:0]    gnt;
   logic [N-1:0]    done;
   logic            err;
   logic [DI-1:0]   wdata_instruction;
   logic            wr_instruction;
   logic            full_instruction = 1'b0;
   logic [DF-1:0]   wdata_data;
   logic            wr_data;
   logic            full_data = 1'b0;
   logic            work;
   logic            op;
   logic            busy = 1'b0;

   int total = 0;
   int bad   = 0;
   int last_m = N - 1;

   jtag_arb #(
      .NUM_REQ(N), .DATA_INSTRUCTION(DI), .DATA_FIFO(DF), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .req_ir(req_ir), .req_dr(req_dr), .req_op(req_op),
      .gnt(gnt), .done(done), .err(err),
      .wdata_instruction(wdata_instruction), .wr_instruction(wr_instruction),
      .full_instruction(full_instruction),
      .wdata_data(wdata_data), .wr_data(wr_data), .full_data(full_data),
      .work(work), .op(op), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   // Reference: first requester found walking upward from the one after the last owner.
   function automatic int pick(input logic [N-1:0] r, input int last);
      logic [N-1:0] t;
      for (int k = 1; k <= N; k++) begin
         t = r >> ((last + k) % N);
         if (t[0]) return (last + k) % N;
      end
      return 0;
   endfunction

   task automatic rand_inputs;
      req_ir = IRW'($urandom);
      req_dr = DRW'($urandom);
      req_op = N'($urandom);
   endtask

   // Caller drives req/ir/dr/op while the arbiter is idle; returns in the done cycle.
   task automatic run_txn(input bit hold, input bit use_fi, input int nfull,
                          input bit pre, input int dly, input int len);
      int            own;
      logic [DI-1:0] eir;
      logic [DF-1:0] edr;
      logic          eop;
      own = pick(req, last_m);
      eir = req_ir[own*DI +: DI];
      edr = req_dr[own*DF +: DF];
      eop = req_op[own];
      tick;
      check("latch_gnt", gnt, 0);
      check("latch_wr", {wr_instruction, wr_data}, 0);
      check("latch_done", done, 0);
      rand_inputs();
      if (!hold) req = '0;
      if (nfull > 0) begin
         if (use_fi) full_instruction = 1'b1;
         else full_data = 1'b1;
      end
      for (int i = 0; i < nfull; i++) begin
         tick;
         check("full_gnt", gnt, 0);
         check("full_wr", {wr_instruction, wr_data}, 0);
      end
      full_instruction = 1'b0;
      full_data = 1'b0;
      tick;
      check("push_gnt", gnt, 32'd1 << own);
      check("push_wr", {wr_instruction, wr_data}, 2'b11);
      check("push_wdata_ir", wdata_instruction, eir);
      check("push_wdata_dr", wdata_data, edr);
      check("push_work", work, 0);
      last_m = own;
      if (pre) busy = 1'b1;
      tick;
      check("start_work", work, 1);
      check("start_op", op, eop);
      check("start_gnt", gnt, 0);
      check("start_wr", {wr_instruction, wr_data}, 0);
      if (!pre) begin
         for (int i = 0; i < dly; i++) begin
            tick;
            check("wbusy_done", done, 0);
         end
         busy = 1'b1;
      end
      for (int i = 0; i < len; i++) begin
         tick;
         check("busy_work", work, 0);
         check("busy_done", done, 0);
      end
      busy = 1'b0;
      tick;
      check("done", done, 32'd1 << own);
      check("done_gnt", gnt, 0);
   endtask

   initial begin
      bit h;
      int own_r;
      rst = 1'b0;
      tick;
      tick;
      check("rst_gnt", gnt, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_wr", {wr_instruction, wr_data}, 0);
      check("rst_wdata", {wdata_instruction, wdata_data}, 0);
      check("rst_work_op", {work, op}, 0);
      rst = 1'b1;
      tick;

      // Single request with fixed words, long busy.
      rand_inputs();
      req = 3'b001;
      req_ir[DI-1:0] = 10'h2A5;
      req_dr[DF-1:0] = 8'h3C;
      req_op[0] = 1'b1;
      run_txn(1'b0, 1'b0, 0, 1'b0, 0, 10);
      tick;
      check("done_pulse", done, 0);

      // Two requesters held continuously alternate.
      req = 3'b011;
      rand_inputs();
      for (int t = 0; t < 4; t++) run_txn(1'b1, 1'b0, 0, 1'b0, 1, 2);
      req = '0;
      tick;

      // FIFO-full backpressure on each side.
      req = 3'b110;
      rand_inputs();
      run_txn(1'b0, 1'b0, 6, 1'b0, 0, 3);
      req = 3'b101;
      rand_inputs();
      run_txn(1'b0, 1'b1, 4, 1'b1, 0, 1);

      for (int t = 0; t < 24; t++) begin
         req = N'($urandom_range(1, (1 << N) - 1));
         rand_inputs();
         h = 1'($urandom_range(0, 1));
         run_txn(h, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), $urandom_range(1, 6));
         if ($urandom_range(0, 1) == 1) begin
            req = '0;
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
               tick;
               check("gap_gnt", gnt, 0);
            end
         end
      end

      // Reset while the engine is busy.
      req = 3'b100;
      rand_inputs();
      tick;
      req = '0;
      tick;
      tick;
      busy = 1'b1;
      tick;
      tick;
      rst = 1'b0;
      #1;
      check("arst_gnt", gnt, 0);
      check("arst_done", done, 0);
      check("arst_err", err, 0);
      check("arst_wr", {wr_instruction, wr_data}, 0);
      check("arst_wdata", {wdata_instruction, wdata_data}, 0);
      check("arst_work_op", {work, op}, 0);
      busy = 1'b0;
      tick;
      tick;
      check("arst_no_done", done, 0);
      rst = 1'b1;
      last_m = N - 1;
      tick;
      req = 3'b111;
      rand_inputs();
      run_txn(1'b0, 1'b0, 0, 1'b0, 2, 4);

`ifdef JTAG_ARB_TIMEOUT_EN
      // Engine never reports busy: watchdog aborts.
      tick;
      req = 3'b010;
      rand_inputs();
      own_r = pick(req, last_m);
      tick;
      req = '0;
      tick;
      check("tmo_gnt", gnt, 32'd1 << own_r);
      last_m = own_r;
      tick;
      for (int i = 1; i < TO; i++) begin
         tick;
         check("tmo_err_early", err, 0);
      end
      tick;
      check("tmo_err", err, 1);
      check("tmo_done", done, 0);
      tick;
      check("tmo_err_pulse", err, 0);
      check("tmo_done_after", done, 0);
      req = 3'b011;
      rand_inputs();
      run_txn(1'b0, 1'b0, 0, 1'b0, 0, 2);
`else
      own_r = 0;
`endif

      tick;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jtag_arb.md
# jtag_arb

Round-robin arbiter and sequencer that shares the single JTAG engine and its instruction/data FIFO pair among several command requesters. It accepts one transaction (instruction word, data byte, opcode) at a time from the requester whose turn it is. It pushes the instruction word and data byte atomically into the two FIFOs, starts the engine with a `work` pulse, and tracks `busy` to report completion back to the owner. It sits between the command sources and the FIFO/engine datapath, replacing a single fixed producer.

## Interface
- `NUM_REQ`, 2: number of requesters; range 2..8.
- `DATA_INSTRUCTION`, 10: instruction FIFO word width.
- `DATA_FIFO`, 8: data FIFO word width.
- `TIMEOUT`, 255: watchdog limit in clk cycles; only used with `JTAG_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: single system clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req` in NUM_REQ: per-requester transaction request; held high until `gnt`.
- `req_ir` in NUM_REQ*DATA_INSTRUCTION: instruction word; slice i belongs to requester i.
- `req_dr` in NUM_REQ*DATA_FIFO: data byte; slice i belongs to requester i.
- `req_op` in NUM_REQ: operation select per requester.
- `gnt` out NUM_REQ: one-cycle pulse; the requester's transaction has been pushed.
- `done` out NUM_REQ: one-cycle pulse; the engine has finished the owner's transaction.
- `err` out 1: one-cycle pulse on watchdog abort.
- `wdata_instruction` out DATA_INSTRUCTION, `wr_instruction` out 1, `full_instruction` in 1: instruction FIFO write side.
- `wdata_data` out DATA_FIFO, `wr_data` out 1, `full_data` in 1: data FIFO write side.
- `work` out 1, `op` out 1, `busy` in 1: engine start handshake.

## Operation
- States: IDLE, PUSH, START, WAIT_BUSY, WAIT_DONE.
- IDLE, `req` nonzero: choose a winner.
  - Search order starts at `(last+1) mod NUM_REQ`.
  - Latch owner index, its `req_ir`, `req_dr` and `req_op` slices.
  - Go to PUSH.
- PUSH, both `full_instruction` and `full_data` low:
  - Assert `wr_instruction`, `wr_data` and `gnt[owner]` together for one cycle.
  - `wdata_*` carry the latched words.
  - Set `last` to the owner; go to START.
- PUSH, either FIFO full: hold with all three low. A partial push is never issued.
- START: `work`=1 for one cycle, `op`=latched op; go to WAIT_BUSY.
- WAIT_BUSY: wait for `busy`=1, then go to WAIT_DONE.
- WAIT_DONE: wait for `busy`=0. Then pulse `done[owner]` for one cycle and go to IDLE.
- Requester inputs are sampled only in IDLE. Changes after that sampling edge do not affect the transaction.
- Requester deasserts `req` after being latched but before `gnt`: the transaction still completes.
- One transaction is in flight at a time. New requests wait in IDLE.

## Timing
- Reset (`rst`=0): state IDLE, `last`=NUM_REQ-1 so requester 0 wins first. All outputs are 0, including `wdata_*`.
- Reset asserted mid-transaction: immediate return to IDLE. No `gnt`, `done` or `err` pulse is emitted. FIFO contents are not touched.
- Request sampled at edge E0, FIFOs not full:
  - `gnt` and `wr_*` high E1→E2.
  - `work` high E2→E3.
- `done` is high during the cycle after the edge where WAIT_DONE samples `busy`=0.
- Back-to-back: IDLE re-arbitrates on the edge ending the `done` cycle. The minimum period per transaction is 5 cycles plus the engine's busy time.
- `busy` already high in START: WAIT_BUSY exits on the next edge.
- `gnt` and `done` are one-hot or zero. `gnt` and `done` never pulse in the same cycle.

## Configuration
- `JTAG_ARB_TIMEOUT_EN` defined:
  - A cycle counter is cleared on entry to WAIT_BUSY and on entry to WAIT_DONE.
  - If the counter reaches `TIMEOUT` in either state, `err` pulses one cycle and the FSM returns to IDLE without a `done`.
  - `last` keeps the owner.
- `JTAG_ARB_TIMEOUT_EN` undefined: no counter is built, `err` is tied 0, and waits are unbounded.

## Test plan
- Single request: `req`=01, ir=0x2A5, dr=0x3C, op=1 → `gnt`=01 at E1, `wr_*` with 0x2A5/0x3C at E1, `work`/`op`=1 at E2. With busy high 10 cycles, `done`=01 one cycle after busy falls.
- Fairness: `req`=11 held continuously for 4 transactions → grant order 0,1,0,1.
- FIFO full: `full_data`=1 for 6 cycles in PUSH → no `wr_*`/`gnt` during those cycles. Push occurs on the cycle after it clears, with both writes in the same cycle.
- Input change after latch: alter `req_ir` slice the cycle after E0 → the originally latched value is written.
- Reset mid-WAIT_DONE: drop `rst` → all outputs 0 immediately, no `done`. After release, the next request is served normally.
- With `JTAG_ARB_TIMEOUT_EN`, TIMEOUT=20, `busy` never rises → `err` pulses one cycle, 20 cycles after entering WAIT_BUSY. FSM is back in IDLE and `done` stays 0.
